wb_display_mux: RTL and testbench

- Next-generation Wishbone display slave driving an N-digit multiplexed 7-segment display.
- Generalised in digit count and scan rate; adds per-digit decimal point and blanking, a global enable, and tear-free data update.
- Bus-facing register block plus scan engine and segment decoder in one module.
- Sits on the shared Wishbone bus beside the other peripheral slaves.

---
 rtl/wb_display_mux_if.sv | 30 +++
 rtl/wb_display_mux.sv | 182 ++++++++++++++++++
 tb/tb_wb_display_mux.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_display_mux_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_display_mux_if : Wishbone slave bundle for the display controller  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface wb_display_mux_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 11,
    parameter int GRANULARITY   = 8
);
    logic [WB_ADDR_WIDTH-1:0]               addr_i;
    logic [WB_DATA_WIDTH-1:0]               data_i;
    logic [WB_DATA_WIDTH-1:0]               data_o;
    logic                                   stb_i;
    logic [WB_DATA_WIDTH/GRANULARITY-1:0]   sel_i;
    logic                                   ack_o;
    logic                                   cyc_i;
    logic                                   we_i;

    modport slave (
        input  addr_i, data_i, stb_i, sel_i, cyc_i, we_i,
        output data_o, ack_o
    );

    modport master (
        output addr_i, data_i, stb_i, sel_i, cyc_i, we_i,
        input  data_o, ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_display_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_display_mux : Wishbone slave scanning an N-digit 7-segment display |
// | Optional macro DISPLAY_BRIGHTNESS_EN adds a BRIGHT duty-cycle register|
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module wb_display_mux #(
    parameter int WB_DATA_WIDTH    = 32,
    parameter int WB_ADDR_WIDTH    = 11,
    parameter int GRANULARITY      = 8,
    parameter int SLAVE_ADDR_WIDTH = 1,
    parameter int SLAVE_ADDR       = 1,
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 100000
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    wb_display_mux_if.slave       wb,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            hex_display
);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam int PW    = $clog2(SCAN_DIV);
    localparam int LANES = WB_DATA_WIDTH / GRANULARITY;

    logic [DW-1:0]         pend_q, pend_d, act_q, act_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d, blank_q, blank_d;
    logic                  en_q, en_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    logic                  ack_q, ack_d;
    logic [31:0]           data_q, data_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            hex_q, hex_d;

    logic                  sel_w, acc_w, tc_w, wrap_w, lit_w, on_w, unused_w;
    logic [1:0]            reg_w;
    logic [31:0]           rdata_w, wmerge_w, act_pad_w, pend_pad_w;
    logic [7:0]            dp_pad_w, blank_pad_w, oh_w;
    logic [3:0]            nib_w;

    assign sel_w = wb.cyc_i & wb.stb_i &
        (wb.addr_i[WB_ADDR_WIDTH-1 -: SLAVE_ADDR_WIDTH] == SLAVE_ADDR_WIDTH'(SLAVE_ADDR));
    assign reg_w    = wb.addr_i[3:2];
    assign acc_w    = sel_w & ~ack_q;
    assign unused_w = ^wb.addr_i;

`ifdef DISPLAY_BRIGHTNESS_EN
    localparam int MW = PW + 5;
    logic [3:0]    bright_q, bright_d;
    logic [MW-1:0] thresh_w;
    assign thresh_w = ((MW'(bright_q) + MW'(1)) * MW'(SCAN_DIV)) >> 4;
    assign on_w     = {5'b0, presc_q} < thresh_w;
`else
    assign on_w = 1'b1;
`endif

    // Narrow fields widened to power-of-two vectors so a 3-bit index never overruns
    always_comb begin
        act_pad_w              = '0;
        act_pad_w[DW-1:0]      = act_q;
        pend_pad_w             = '0;
        pend_pad_w[DW-1:0]     = pend_q;
        dp_pad_w               = '0;
        dp_pad_w[NUM_DIGITS-1:0]    = dp_q;
        blank_pad_w            = '0;
        blank_pad_w[NUM_DIGITS-1:0] = blank_q;
    end

    always_comb begin
        rdata_w = '0;
        case (reg_w)
            2'd0: rdata_w = pend_pad_w;
            2'd1: rdata_w = {16'b0, blank_pad_w, dp_pad_w};
            2'd2: rdata_w = {21'b0, idx_q, 7'b0, en_q};
`ifdef DISPLAY_BRIGHTNESS_EN
            2'd3: rdata_w = {28'b0, bright_q};
`endif
            default: rdata_w = '0;
        endcase
    end

    // Byte-lane merge against the current register image; field extraction drops unimplemented bits
    always_comb begin
        wmerge_w = rdata_w;
        for (int l = 0; l < LANES; l++) begin
            if (wb.sel_i[l]) wmerge_w[l*GRANULARITY +: GRANULARITY] = wb.data_i[l*GRANULARITY +: GRANULARITY];
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign tc_w   = (presc_q == PW'(SCAN_DIV - 1));
    assign wrap_w = tc_w && (idx_q == 3'(NUM_DIGITS - 1));
    assign nib_w  = act_pad_w[{idx_q, 2'b00} +: 4];
    assign oh_w   = 8'b1 << idx_q;
    assign lit_w  = en_q & ~blank_pad_w[idx_q] & on_w;

    always_comb begin
        ack_d   = acc_w;
        data_d  = (acc_w && !wb.we_i) ? rdata_w : 32'b0;
        pend_d  = pend_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        en_d    = en_q;
`ifdef DISPLAY_BRIGHTNESS_EN
        bright_d = bright_q;
`endif
        if (acc_w && wb.we_i) begin
            case (reg_w)
                2'd0: pend_d = wmerge_w[DW-1:0];
                2'd1: begin
                    dp_d    = wmerge_w[NUM_DIGITS-1:0];
                    blank_d = wmerge_w[8 +: NUM_DIGITS];
                end
                2'd2: en_d = wmerge_w[0];
`ifdef DISPLAY_BRIGHTNESS_EN
                2'd3: bright_d = wmerge_w[3:0];
`endif
                default: ;
            endcase
        end
        presc_d = tc_w ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tc_w) idx_d = wrap_w ? 3'd0 : idx_q + 3'd1;
        // Pending value (pre-write) is promoted only at the wrap to digit 0
        act_d   = wrap_w ? pend_q : act_q;
        an_d    = lit_w ? ~oh_w[NUM_DIGITS-1:0] : '1;
        hex_d   = lit_w ? {~dp_pad_w[idx_q], seg7(nib_w)} : 8'hFF;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q   <= 1'b0;
            data_q  <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            en_q    <= 1'b1;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            hex_q   <= 8'hFF;
`ifdef DISPLAY_BRIGHTNESS_EN
            bright_q <= 4'hF;
`endif
        end else begin
            ack_q   <= ack_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            en_q    <= en_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            hex_q   <= hex_d;
`ifdef DISPLAY_BRIGHTNESS_EN
            bright_q <= bright_d;
`endif
        end
    end

    assign wb.ack_o    = ack_q;
    assign wb.data_o   = data_q;
    assign an          = an_q;
    assign hex_display = hex_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_display_mux.sv
`default_nettype none
// Directed-vector bench for wb_display_mux (4 digits, short scan divider).
module tb_wb_display_mux;
`ifdef DISPLAY_BRIGHTNESS_EN
    localparam int SD = 16;
`else
    localparam int SD = 4;
`endif
    localparam int ND = 4;
    localparam logic [1:0] R_DATA = 2'd0, R_MASK = 2'd1, R_CTRL = 2'd2, R_BRIGHT = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [ND-1:0] an;
    logic [7:0]    hex;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   rd;

    wb_display_mux_if #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(11), .GRANULARITY(8)) bus ();

    wb_display_mux #(
        .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(11), .GRANULARITY(8),
        .SLAVE_ADDR_WIDTH(1), .SLAVE_ADDR(1), .NUM_DIGITS(ND), .SCAN_DIV(SD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wb(bus), .an(an), .hex_display(hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe held for two edges: ack must appear on the first and drop on the second
    task automatic wb_xfer(input logic [1:0] r, input logic we, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rdata);
        check("ack_idle", {31'b0, bus.ack_o}, 32'd0);
        bus.cyc_i  = 1'b1;
        bus.stb_i  = 1'b1;
        bus.we_i   = we;
        bus.addr_i = {1'b1, 6'b0, r, 2'b00};
        bus.data_i = wd;
        bus.sel_i  = sel;
        tick();
        check("ack_rise", {31'b0, bus.ack_o}, 32'd1);
        rdata = bus.data_o;
        tick();
        check("ack_single", {31'b0, bus.ack_o}, 32'd0);
        check("data_idle", bus.data_o, 32'd0);
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    // Returns on the first cycle digit 0 is shown after a wrap
    task automatic sync_slot0();
        logic [ND-1:0] prev;
        bit            found = 1'b0;
        prev = an;
        for (int i = 0; i < 4 * ND * SD; i++) begin
            tick();
            if (an == 4'hE && prev != 4'hE) begin
                found = 1'b1;
                break;
            end
            prev = an;
        end
        if (!found) check("slot0_sync", {28'b0, an}, 32'hE);
    endtask

    initial begin
        int act_cnt, d_cnt, f_cnt, bad_hex;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.addr_i = '0; bus.data_i = '0; bus.sel_i = '0;

        repeat (3) tick();
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_hex", {24'b0, hex}, 32'hFF);
        check("rst_ack", {31'b0, bus.ack_o}, 32'd0);
        rst = 1'b1;

        tick();
        check("walk0_an", {28'b0, an}, 32'hE);
        check("walk0_hex", {24'b0, hex}, 32'hC0);
        repeat (SD) tick();
        check("walk1_an", {28'b0, an}, 32'hD);
        repeat (SD) tick();
        check("walk2_an", {28'b0, an}, 32'hB);
        repeat (SD) tick();
        check("walk3_an", {28'b0, an}, 32'h7);

        sync_slot0();
        wb_xfer(R_DATA, 1'b1, 32'h0000_1234, 4'hF, rd);
        check("tearfree_old", {24'b0, hex}, 32'hC0);
        wb_xfer(R_DATA, 1'b0, 32'h0, 4'hF, rd);
        check("rd_data1234", rd, 32'h0000_1234);
        sync_slot0();
        check("digit0_4", {24'b0, hex}, 32'h99);
        repeat (SD) tick();
        check("digit1_3", {24'b0, hex}, 32'hB0);

        sync_slot0();
        wb_xfer(R_DATA, 1'b1, 32'hFFFF_FF56, 4'b0001, rd);
        wb_xfer(R_DATA, 1'b0, 32'h0, 4'hF, rd);
        check("rd_bytelane", rd, 32'h0000_1256);
        sync_slot0();
        check("digit0_6", {24'b0, hex}, 32'h82);

        sync_slot0();
        wb_xfer(R_MASK, 1'b1, 32'h0000_0201, 4'hF, rd);
        check("dp_hex", {24'b0, hex}, 32'h02);
        check("dp_an", {28'b0, an}, 32'hE);
        wb_xfer(R_MASK, 1'b0, 32'h0, 4'hF, rd);
        check("rd_mask", rd, 32'h0000_0201);
        d_cnt = 0; f_cnt = 0;
        for (int i = 0; i < ND * SD; i++) begin
            tick();
            if (an == 4'hD) d_cnt++;
            if (an == 4'hF) f_cnt++;
        end
        check("blank_d_cnt", d_cnt, 32'd0);
        check("blank_f_cnt", f_cnt, SD);

        wb_xfer(R_MASK, 1'b1, 32'h0, 4'hF, rd);
        wb_xfer(R_CTRL, 1'b1, 32'h0, 4'hF, rd);
        check("en0_an", {28'b0, an}, 32'hF);
        check("en0_hex", {24'b0, hex}, 32'hFF);
        wb_xfer(R_CTRL, 1'b0, 32'h0, 4'hF, rd);
        check("ctrl_unimpl", rd & ~32'h0000_0700, 32'h0);
        wb_xfer(R_CTRL, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        wb_xfer(R_CTRL, 1'b0, 32'h0, 4'hF, rd);
        check("ctrl_en1", rd & ~32'h0000_0700, 32'h1);

        wb_xfer(R_DATA, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        wb_xfer(R_DATA, 1'b0, 32'h0, 4'hF, rd);
        check("data_unimpl", rd, 32'h0000_FFFF);

        // Reset asserted alongside a write strobe
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.addr_i = {1'b1, 6'b0, R_MASK, 2'b00};
        bus.data_i = 32'h0000_0F0F; bus.sel_i = 4'hF;
        rst = 1'b0;
        tick();
        check("rstmid_ack0", {31'b0, bus.ack_o}, 32'd0);
        check("rstmid_an", {28'b0, an}, 32'hF);
        tick();
        check("rstmid_ack1", {31'b0, bus.ack_o}, 32'd0);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        rst = 1'b1;
        tick();
        wb_xfer(R_DATA, 1'b0, 32'h0, 4'hF, rd);
        check("rstmid_data", rd, 32'h0);
        wb_xfer(R_MASK, 1'b0, 32'h0, 4'hF, rd);
        check("rstmid_mask", rd, 32'h0);
        wb_xfer(R_CTRL, 1'b0, 32'h0, 4'hF, rd);
        check("rstmid_en", rd & 32'h1, 32'h1);

        wb_xfer(R_BRIGHT, 1'b1, 32'h0000_0003, 4'hF, rd);
        wb_xfer(R_BRIGHT, 1'b0, 32'h0, 4'hF, rd);
`ifdef DISPLAY_BRIGHTNESS_EN
        check("rd_bright", rd, 32'h3);
`else
        check("rd_bright", rd, 32'h0);
`endif
        act_cnt = 0; bad_hex = 0;
        for (int i = 0; i < ND * SD; i++) begin
            tick();
            if (an != 4'hF) act_cnt++;
            else if (hex != 8'hFF) bad_hex++;
        end
`ifdef DISPLAY_BRIGHTNESS_EN
        check("duty_cnt", act_cnt, ND * 4);
`else
        check("duty_cnt", act_cnt, ND * SD);
`endif
        check("dark_hex", bad_hex, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
